// File: rtl/morse_pkg.sv
// Shared Morse definitions for the encoder and the receiver.
// Contents: FSM states, unit lengths, the code-entry layout and the ASCII ranges.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_e;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;

  // pat is right-aligned: element i of len is pat[len-1-i]; 1 = dash, 0 = dot.
  // A valid entry with len == 0 means ASCII space (word gap only).
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  localparam logic [7:0] ASC_SPACE    = 8'h20;
  localparam logic [7:0] ASC_DIG_LO   = 8'h30;
  localparam logic [7:0] ASC_DIG_HI   = 8'h39;
  localparam logic [7:0] ASC_UP_LO    = 8'h41;
  localparam logic [7:0] ASC_UP_HI    = 8'h5A;
  localparam logic [7:0] ASC_LO_LO    = 8'h61;
  localparam logic [7:0] ASC_LO_HI    = 8'h7A;
  localparam logic [7:0] ASC_CASE_OFS = 8'h20;

  // Unit-counter load value for a mark: the counter runs down to 0.
  function automatic logic [2:0] mark_last(input logic dash);
    return dash ? 3'(DASH_UNITS - 1) : 3'(DOT_UNITS - 1);
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character-in / Morse-line-out bundle of the Morse encoder.
// State is exported for debug and checker binding.
interface morse_encoder_if;
  import morse_pkg::*;

  // char_in transfers on a rising clk edge where char_valid && char_ready are both 1;
  // char_in is only sampled on that edge, and char_valid may stay high across transfers.
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       serial_out;
  logic       busy;
  logic       err;
  state_e     state;

  modport master (
    output char_in, char_valid,
    input  char_ready, serial_out, busy, err, state
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, serial_out, busy, err, state
  );

endinterface

// File: rtl/morse_code_rom.sv
// Combinational ASCII -> {valid, len, pat} Morse lookup.
// Define MORSE_LOWERCASE_EN to fold a-z onto A-Z before the lookup.
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid,
  output code_t      code
);

  logic [7:0] c;

  always_comb begin
    c = ch;
`ifdef MORSE_LOWERCASE_EN
    if (ch >= ASC_LO_LO && ch <= ASC_LO_HI) c = ch - ASC_CASE_OFS;
`endif
  end

  always_comb begin
    valid = 1'b1;
    code  = '0;
    if (c == ASC_SPACE) begin
      code = '0;
    end else if (c >= ASC_DIG_LO && c <= ASC_DIG_HI) begin
      // Digits: d<=5 is d dots then dashes, d>5 is (d-5) dashes then dots.
      code.len = 3'd5;
      code.pat = (c[3:0] <= 4'd5) ? (5'b11111 >> c[3:0])
                                  : (5'b11111 << (4'd10 - c[3:0]));
    end else if (c >= ASC_UP_LO && c <= ASC_UP_HI) begin
      case (c)
        8'h41:   code = '{3'd2, 5'b00001};  // A .-
        8'h42:   code = '{3'd4, 5'b01000};  // B -...
        8'h43:   code = '{3'd4, 5'b01010};  // C -.-.
        8'h44:   code = '{3'd3, 5'b00100};
        8'h45:   code = '{3'd1, 5'b00000};
        8'h46:   code = '{3'd4, 5'b00010};
        8'h47:   code = '{3'd3, 5'b00110};
        8'h48:   code = '{3'd4, 5'b00000};
        8'h49:   code = '{3'd2, 5'b00000};
        8'h4A:   code = '{3'd4, 5'b00111};
        8'h4B:   code = '{3'd3, 5'b00101};
        8'h4C:   code = '{3'd4, 5'b00100};
        8'h4D:   code = '{3'd2, 5'b00011};
        8'h4E:   code = '{3'd2, 5'b00010};
        8'h4F:   code = '{3'd3, 5'b00111};
        8'h50:   code = '{3'd4, 5'b00110};
        8'h51:   code = '{3'd4, 5'b01101};
        8'h52:   code = '{3'd3, 5'b00010};
        8'h53:   code = '{3'd3, 5'b00000};
        8'h54:   code = '{3'd1, 5'b00001};
        8'h55:   code = '{3'd3, 5'b00001};
        8'h56:   code = '{3'd4, 5'b00001};
        8'h57:   code = '{3'd3, 5'b00011};
        8'h58:   code = '{3'd4, 5'b01001};
        8'h59:   code = '{3'd4, 5'b01011};
        default: code = '{3'd4, 5'b01100};  // Z --..
      endcase
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// Serialises one ASCII character per handshake onto a Morse on/off line.
// Optional lowercase support is selected by MORSE_LOWERCASE_EN (see morse_code_rom).
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1,
  parameter int ELEM_GAP    = 2,
  parameter int CHAR_GAP    = 3,
  parameter int WORD_GAP    = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  morse_encoder_if.slave  bus
);

  localparam int             PW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(UNIT_CYCLES - 1);
  localparam logic [2:0]     ELEM_LAST = 3'(ELEM_GAP - 1);
  localparam logic [2:0]     CHAR_LAST = 3'(CHAR_GAP - 1);
  localparam logic [2:0]     WORD_LAST = 3'(WORD_GAP - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    units_q, units_d;
  logic [2:0]    elem_q, elem_d;
  logic [4:0]    pat_q, pat_d;
  logic          serial_q, serial_d;
  logic          err_q, err_d;

  logic  rom_valid;
  code_t rom_code;
  logic  ready_w;
  logic  accept;

  morse_code_rom u_rom (
    .ch    (bus.char_in),
    .valid (rom_valid),
    .code  (rom_code)
  );

  assign ready_w = (state_q == IDLE) && rst_n;
  assign accept  = bus.char_valid && ready_w;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    units_d = units_q;
    elem_d  = elem_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        pre_d = '0;
        if (accept) begin
          if (!rom_valid) begin
            err_d = 1'b1;
          end else if (rom_code.len == 3'd0) begin
            state_d = GAP;
            units_d = WORD_LAST;
          end else begin
            state_d = MARK;
            pat_d   = rom_code.pat;
            elem_d  = rom_code.len - 3'd1;
            units_d = mark_last(rom_code.pat[rom_code.len - 3'd1]);
          end
        end
      end
      default: begin
        // units_q holds the units left after the current one; act on the last clock of a unit.
        if (pre_q != PRE_LAST) begin
          pre_d = pre_q + 1'b1;
        end else begin
          pre_d = '0;
          if (units_q != 3'd0) begin
            units_d = units_q - 3'd1;
          end else begin
            case (state_q)
              MARK: begin
                if (elem_q != 3'd0) begin
                  state_d = SPACE;
                  units_d = ELEM_LAST;
                  elem_d  = elem_q - 3'd1;
                end else begin
                  state_d = GAP;
                  units_d = CHAR_LAST;
                end
              end
              SPACE: begin
                state_d = MARK;
                units_d = mark_last(pat_q[elem_q]);
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase
    serial_d = (state_d == MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      units_q  <= '0;
      elem_q   <= '0;
      pat_q    <= '0;
      serial_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      units_q  <= units_d;
      elem_q   <= elem_d;
      pat_q    <= pat_d;
      serial_q <= serial_d;
      err_q    <= err_d;
    end
  end

  assign bus.char_ready = ready_w;
  assign bus.serial_out = serial_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;
  assign bus.state      = state_q;

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
Upstream stage of the Morse receiver. It accepts one ASCII character per valid/ready handshake and serialises it onto a single on/off line, one symbol unit per UNIT_CYCLES clocks. The unit framing is the one the receiver decodes: dot = 1 high unit, dash = 3 high units, 2 low units between elements, 3 low units between characters. serial_out connects directly to the receiver's serial_inp.

Parameters:
UNIT_CYCLES, 1, clocks per Morse unit; must be >= 1; 1 matches the receiver's one-bit-per-clock sampling.
ELEM_GAP, 2, low units between elements of one character.
CHAR_GAP, 3, low units after the last element before ready reasserts.
WORD_GAP, 7, low units emitted for ASCII space (0x20).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
char_in  in  8  ASCII character to send
char_valid  in  1  char_in is valid
char_ready  out  1  encoder can accept a character
serial_out  out  1  Morse on/off line, registered
busy  out  1  a character or gap is in progress
err  out  1  one-cycle pulse: accepted character has no Morse code

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: serial_out=0, busy=0, err=0, char_ready=1, state=IDLE, all counters 0.
- Handshake:
  - char_ready = (state==IDLE) && rst_n.
  - A character transfers on a rising edge with char_valid && char_ready.
  - char_in is sampled only at that edge.
  - char_valid may be held between characters; back-to-back transfers are legal.
- Supported codes: A-Z (0x41-0x5A), 0-9 (0x30-0x39), space (0x20). The lookup returns len (1..5) and a 5-bit pattern. Pattern is MSB-first over len elements; 1=dash, 0=dot.
- FSM states: IDLE, MARK, SPACE, GAP.
  - IDLE, accept of a supported letter/digit: load pattern/len, go to MARK. serial_out=1 from the next cycle (one-cycle latency from accept edge).
  - MARK: hold serial_out=1 for 1 unit (dot) or 3 units (dash). Then go to SPACE if elements remain, else GAP.
  - SPACE: serial_out=0 for ELEM_GAP units, then next element in MARK.
  - GAP: serial_out=0 for CHAR_GAP units (WORD_GAP for space), then IDLE.
  - IDLE with a space: go directly to GAP with WORD_GAP.
  - IDLE with an unsupported code: err=1 on the cycle after accept, no mark emitted, stay in IDLE; char_ready stays 1.
- Counters:
  - Unit prescaler counts 0..UNIT_CYCLES-1.
  - Unit counter is 3 bits (max 7).
  - Element index is 3 bits, counting down from len-1 to 0.
- busy = (state != IDLE).
- Worst-case occupancy (e.g. '0' = 5 dashes): 5*3 + 4*2 + 3 = 26 units.
- Reset mid-operation: serial_out drops to 0 asynchronously. FSM returns to IDLE; no partial-character recovery.
- char_valid while busy: ignored; the character is not lost because char_ready=0 holds it upstream.

Optional Feature:
MORSE_LOWERCASE_EN
- Defined: a-z (0x61-0x7A) fold to uppercase before lookup and encode identically to A-Z.
- Undefined: a-z are unsupported; err pulses and no output is emitted.

Decomposition:
- Package morse_pkg holds:
  - FSM state enum.
  - Unit constants: DOT_UNITS=1, DASH_UNITS=3.
  - Code entry struct {len[2:0], pat[4:0]}.
  - ASCII range constants.
- Package is shared with the receiver.
- One sub-module, morse_code_rom: combinational ASCII -> {valid, len, pat} lookup. Also instantiable by the receiver as a reverse-map reference model.

Test Plan:
1. UNIT_CYCLES=1, send 'E' (0x45).
   - Response: serial_out = 1 for cycle 1 after accept, then 0 for 3 cycles.
   - char_ready reasserts on cycle 5; busy high cycles 1-4.
2. Send 'L' then '4' back-to-back with char_valid held.
   - 'L' = 1,0,0,111,0,0,1,0,0,1,0,0,0.
   - '4' = 1,0,0,1,0,0,1,0,0,1,0,0,111,0,0,0.
   - No extra idle cycle between the two characters.
3. Loopback into the receiver, stream "EL46DIGIPROG".
   - Receiver s_out sequence: 45,4C,34,36,44,49,47,49,50,52,4F,47.
4. Send '#' (0x23) -> err=1 for exactly one cycle, serial_out stays 0, char_ready never drops. Send 'a' -> err without the macro; with MORSE_LOWERCASE_EN, output is identical to 'A' (1,0,0,111,0,0,0).
5. UNIT_CYCLES=4, send 'T' -> serial_out high 12 cycles, low 12 cycles; space (0x20) -> low 28 cycles, busy high throughout.
6. Assert rst_n=0 in the middle of the second dash of 'O' -> serial_out=0 in the same timestep. After release: char_ready=1, busy=0, next 'E' encodes correctly.
